// File: rtl/vc_arbiter_if.sv
// Bundle of VC-side and destination-side FIFO signals around the arbiter.
// The arbiter uses the master view. It drives the pops, the pushes and the status signals.
interface vc_arbiter_if #(
  parameter int DATA_SIZE = 6
);
  logic                 enable;
  logic                 fifo_empty_vc0;
  logic                 fifo_empty_vc1;
  logic [DATA_SIZE-1:0] data_vc0;
  logic [DATA_SIZE-1:0] data_vc1;
  logic                 fifo_pause_d0;
  logic                 fifo_pause_d1;
  logic                 pop_vc0;
  logic                 pop_vc1;
  logic                 push_d0;
  logic                 push_d1;
  logic [DATA_SIZE-1:0] data_d0;
  logic [DATA_SIZE-1:0] data_d1;
  logic                 arb_idle;
  logic [7:0]           stall_count;

  modport master (
    input  enable, fifo_empty_vc0, fifo_empty_vc1, data_vc0, data_vc1,
           fifo_pause_d0, fifo_pause_d1,
    output pop_vc0, pop_vc1, push_d0, push_d1, data_d0, data_d1,
           arb_idle, stall_count
  );

  modport slave (
    output enable, fifo_empty_vc0, fifo_empty_vc1, data_vc0, data_vc1,
           fifo_pause_d0, fifo_pause_d1,
    input  pop_vc0, pop_vc1, push_d0, push_d1, data_d0, data_d1,
           arb_idle, stall_count
  );
endinterface

// File: rtl/vc_arbiter.sv
// Weighted round-robin scheduler from two VC FIFOs to two destination FIFOs.
// One word is in flight at a time: IDLE -> POP -> CAPTURE -> SEND.
// The word waits in SEND while its destination pauses.
module vc_arbiter #(
  parameter int DATA_SIZE  = 6,
  parameter int DEST_BIT   = 4,
  parameter int VC0_WEIGHT = 3
) (
  input logic         clk,
  input logic         reset,
  vc_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, POP, CAPTURE, SEND} state_t;

  localparam logic [2:0] WEIGHT = 3'(VC0_WEIGHT);

  state_t               state;
  state_t               state_nxt;
  logic                 gnt;
  logic [2:0]           wrr_cnt;
  logic [DATA_SIZE-1:0] hold;
  logic                 dest;
  logic [DATA_SIZE-1:0] last_d0;
  logic [DATA_SIZE-1:0] last_d1;
  logic [7:0]           stall_cnt;

  logic                 req;
  logic                 sel_vc0;
  logic                 pause_sel;
  logic                 push_ok;
  logic [DATA_SIZE-1:0] word_in;

  // The WRR counter tops out at the VC0 weight. Reaching the weight hands the next contended grant to VC1.
  function automatic logic [2:0] wrr_inc(input logic [2:0] c);
    return (c >= WEIGHT) ? WEIGHT : c + 3'd1;
  endfunction

  // The stall counter sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  assign req       = bus.enable && (!bus.fifo_empty_vc0 || !bus.fifo_empty_vc1);
  assign sel_vc0   = !bus.fifo_empty_vc0 && (bus.fifo_empty_vc1 || (wrr_cnt < WEIGHT));
  assign pause_sel = dest ? bus.fifo_pause_d1 : bus.fifo_pause_d0;
  assign push_ok   = (state == SEND) && !pause_sel;
  assign word_in   = gnt ? bus.data_vc1 : bus.data_vc0;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = POP;
      POP:     state_nxt = CAPTURE;
      CAPTURE: state_nxt = SEND;
      SEND:    if (!pause_sel) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes and output data. A pushed word shows up in the push cycle. Otherwise the last pushed word stays on the output.
  always_comb begin
    bus.pop_vc0     = (state == POP) && !gnt;
    bus.pop_vc1     = (state == POP) && gnt;
    bus.push_d0     = push_ok && !dest;
    bus.push_d1     = push_ok && dest;
    bus.data_d0     = (push_ok && !dest) ? hold : last_d0;
    bus.data_d1     = (push_ok && dest) ? hold : last_d1;
    bus.arb_idle    = (state == IDLE);
    bus.stall_count = stall_cnt;
  end

  // Grant and WRR update, word capture, last-pushed data, stall counting.
  // A reset discards the held word.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt       <= 1'b0;
      wrr_cnt   <= 3'd0;
      hold      <= '0;
      dest      <= 1'b0;
      last_d0   <= '0;
      last_d1   <= '0;
      stall_cnt <= 8'd0;
    end else begin
      if ((state == IDLE) && req) begin
        gnt     <= !sel_vc0;
        wrr_cnt <= sel_vc0 ? wrr_inc(wrr_cnt) : 3'd0;
      end
      if (state == CAPTURE) begin
        hold <= word_in;
        dest <= word_in[DEST_BIT];
      end
      if (push_ok && !dest) last_d0 <= hold;
      if (push_ok && dest)  last_d1 <= hold;
      if ((state == SEND) && pause_sel) stall_cnt <= sat_inc8(stall_cnt);
    end
  end

endmodule

// File: tb/tb_vc_arbiter.sv
// Directed testbench for vc_arbiter.
// Behavioural VC FIFOs feed the DUT. Each scenario task checks its own expected values.
module tb_vc_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  vc_arbiter_if #(.DATA_SIZE(6)) bus();

  vc_arbiter #(.DATA_SIZE(6), .DEST_BIT(4), .VC0_WEIGHT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural VC FIFOs. Read data is valid the cycle after the pop.
  logic [5:0] mem0 [0:63];
  logic [5:0] mem1 [0:63];
  logic [5:0] rd0 = '0;
  logic [5:0] rd1 = '0;
  logic [5:0] wr0 = '0;
  logic [5:0] wr1 = '0;
  logic [5:0] q0  = '0;
  logic [5:0] q1  = '0;

  always @(posedge clk) begin
    if (bus.pop_vc0) begin
      q0  <= mem0[rd0];
      rd0 <= rd0 + 6'd1;
    end
    if (bus.pop_vc1) begin
      q1  <= mem1[rd1];
      rd1 <= rd1 + 6'd1;
    end
  end

  assign bus.fifo_empty_vc0 = (rd0 == wr0);
  assign bus.fifo_empty_vc1 = (rd1 == wr1);
  assign bus.data_vc0       = q0;
  assign bus.data_vc1       = q1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load0(input logic [5:0] w);
    mem0[wr0] = w;
    wr0 = wr0 + 6'd1;
  endtask

  task automatic load1(input logic [5:0] w);
    mem1[wr1] = w;
    wr1 = wr1 + 6'd1;
  endtask

  task automatic flush();
    wr0 = rd0;
    wr1 = rd1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.fifo_pause_d0 = 1'b0;
    bus.fifo_pause_d1 = 1'b0;
    tick();
    tick();
    n_vec++;
    if ({bus.pop_vc0, bus.pop_vc1, bus.push_d0, bus.push_d1, bus.arb_idle} !== 5'b00001) begin
      n_err++;
      $display("FAIL reset_strobes: got %b want 00001",
               {bus.pop_vc0, bus.pop_vc1, bus.push_d0, bus.push_d1, bus.arb_idle});
    end
    n_vec++;
    if ({bus.data_d0, bus.data_d1, bus.stall_count} !== 20'h0) begin
      n_err++;
      $display("FAIL reset_data: d0=%h d1=%h stall=%0d want 0 0 0",
               bus.data_d0, bus.data_d1, bus.stall_count);
    end
    reset = 1'b0;
    bus.enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_vec++;
      if ({bus.pop_vc0, bus.pop_vc1, bus.push_d0, bus.push_d1, bus.arb_idle, bus.stall_count} !== 13'b00001_00000000) begin
        n_err++;
        $display("FAIL idle_empty cyc %0d: pops=%b%b pushes=%b%b idle=%b stall=%0d want all 0, idle 1",
                 i, bus.pop_vc0, bus.pop_vc1, bus.push_d0, bus.push_d1, bus.arb_idle, bus.stall_count);
      end
    end
  endtask

  task automatic test_single();
    load0(6'b010101);
    tick();
    n_vec++;
    if ({bus.pop_vc0, bus.pop_vc1, bus.arb_idle} !== 3'b100) begin
      n_err++;
      $display("FAIL single_pop: pop0/pop1/idle=%b want 100", {bus.pop_vc0, bus.pop_vc1, bus.arb_idle});
    end
    tick();
    n_vec++;
    if ({bus.pop_vc0, bus.pop_vc1, bus.push_d0, bus.push_d1} !== 4'b0000) begin
      n_err++;
      $display("FAIL single_capture: strobes=%b want 0000", {bus.pop_vc0, bus.pop_vc1, bus.push_d0, bus.push_d1});
    end
    tick();
    n_vec++;
    if ({bus.push_d0, bus.push_d1, bus.data_d1} !== {2'b01, 6'b010101}) begin
      n_err++;
      $display("FAIL single_push: push0=%b push1=%b d1=%b want 0 1 010101",
               bus.push_d0, bus.push_d1, bus.data_d1);
    end
    tick();
    n_vec++;
    if ({bus.arb_idle, bus.push_d1, bus.data_d1, bus.data_d0} !== {2'b10, 6'b010101, 6'b000000}) begin
      n_err++;
      $display("FAIL single_after: idle=%b push1=%b d1=%b d0=%b want 1 0 010101 000000",
               bus.arb_idle, bus.push_d1, bus.data_d1, bus.data_d0);
    end
  endtask

  task automatic test_wrr();
    logic [7:0] exp_g;
    logic       got;
    exp_g = 8'b1000_1000;
    bus.enable = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    flush();
    for (int i = 0; i < 8; i++) begin
      load0(6'(i + 1));
      load1(6'(i + 33));
    end
    bus.enable = 1'b1;
    for (int t = 0; t < 8; t++) begin
      got = 1'b0;
      for (int k = 0; k < 12 && !got; k++) begin
        if (bus.pop_vc0 || bus.pop_vc1) got = 1'b1;
        else tick();
      end
      n_vec++;
      if (!got) begin
        n_err++;
        $display("FAIL wrr_timeout txn %0d: no pop seen", t);
      end else if ({bus.pop_vc0, bus.pop_vc1} !== {~exp_g[t], exp_g[t]}) begin
        n_err++;
        $display("FAIL wrr_grant txn %0d: pop0/pop1=%b%b want %b%b",
                 t, bus.pop_vc0, bus.pop_vc1, ~exp_g[t], exp_g[t]);
      end
      if (t == 7) bus.enable = 1'b0;
      tick();
    end
    for (int k = 0; k < 10 && !bus.arb_idle; k++) tick();
    flush();
    tick();
    n_vec++;
    if ({bus.arb_idle, bus.pop_vc0, bus.pop_vc1} !== 3'b100) begin
      n_err++;
      $display("FAIL wrr_disable: idle/pop0/pop1=%b want 100", {bus.arb_idle, bus.pop_vc0, bus.pop_vc1});
    end
  endtask

  task automatic test_pause();
    bus.fifo_pause_d0 = 1'b1;
    bus.fifo_pause_d1 = 1'b1;
    load1(6'b000011);
    bus.enable = 1'b1;
    tick();
    n_vec++;
    if ({bus.pop_vc0, bus.pop_vc1} !== 2'b01) begin
      n_err++;
      $display("FAIL pause_pop: pop0/pop1=%b want 01", {bus.pop_vc0, bus.pop_vc1});
    end
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if ({bus.push_d0, bus.push_d1, bus.arb_idle} !== 3'b000) begin
        n_err++;
        $display("FAIL pause_hold cyc %0d: push0/push1/idle=%b want 000",
                 i, {bus.push_d0, bus.push_d1, bus.arb_idle});
      end
      tick();
    end
    n_vec++;
    if (bus.stall_count !== 8'd5) begin
      n_err++;
      $display("FAIL pause_stall_count: got %0d want 5", bus.stall_count);
    end
    bus.fifo_pause_d0 = 1'b0;
    #1;
    n_vec++;
    if ({bus.push_d0, bus.push_d1, bus.data_d0} !== {2'b10, 6'b000011}) begin
      n_err++;
      $display("FAIL pause_release: push0=%b push1=%b d0=%b want 1 0 000011",
               bus.push_d0, bus.push_d1, bus.data_d0);
    end
    tick();
    n_vec++;
    if ({bus.arb_idle, bus.push_d0, bus.stall_count} !== {2'b10, 8'd5}) begin
      n_err++;
      $display("FAIL pause_after: idle=%b push0=%b stall=%0d want 1 0 5",
               bus.arb_idle, bus.push_d0, bus.stall_count);
    end
  endtask

  task automatic test_reset_mid();
    bus.fifo_pause_d0 = 1'b1;
    load1(6'b000111);
    tick();
    tick();
    tick();
    tick();
    tick();
    n_vec++;
    if ({bus.arb_idle, bus.stall_count} !== {1'b0, 8'd7}) begin
      n_err++;
      $display("FAIL midrst_pre: idle=%b stall=%0d want 0 7", bus.arb_idle, bus.stall_count);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++;
    if ({bus.arb_idle, bus.push_d0, bus.push_d1, bus.stall_count, bus.data_d0} !== {3'b100, 8'd0, 6'd0}) begin
      n_err++;
      $display("FAIL midrst_state: idle=%b push=%b%b stall=%0d d0=%b want 1 00 0 000000",
               bus.arb_idle, bus.push_d0, bus.push_d1, bus.stall_count, bus.data_d0);
    end
    bus.fifo_pause_d0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_vec++;
      if ({bus.push_d0, bus.push_d1, bus.pop_vc1, bus.data_d0} !== {3'b000, 6'd0}) begin
        n_err++;
        $display("FAIL midrst_dropped cyc %0d: push=%b%b pop1=%b d0=%b want 000 000000",
                 i, bus.push_d0, bus.push_d1, bus.pop_vc1, bus.data_d0);
      end
    end
  endtask

  task automatic test_routing();
    logic [5:0] got0 [0:3];
    logic [5:0] got1 [0:3];
    int         n0;
    int         n1;
    int         ovl;
    n0  = 0;
    n1  = 0;
    ovl = 0;
    bus.fifo_pause_d1 = 1'b0;
    load0(6'h10);
    load0(6'h05);
    load0(6'h1F);
    for (int c = 0; c < 30; c++) begin
      tick();
      if ((bus.push_d0 && bus.push_d1) || (bus.pop_vc0 && bus.pop_vc1)) ovl++;
      if (bus.push_d0 && n0 < 4) begin got0[n0] = bus.data_d0; n0++; end
      if (bus.push_d1 && n1 < 4) begin got1[n1] = bus.data_d1; n1++; end
    end
    n_vec++;
    if (ovl != 0) begin
      n_err++;
      $display("FAIL route_overlap: %0d overlapping strobe cycles want 0", ovl);
    end
    n_vec++;
    if (n0 != 1 || n1 != 2) begin
      n_err++;
      $display("FAIL route_counts: d0 pushes=%0d d1 pushes=%0d want 1 2", n0, n1);
    end else begin
      n_vec++;
      if (got0[0] !== 6'h05) begin
        n_err++;
        $display("FAIL route_d0: got %h want 05", got0[0]);
      end
      n_vec++;
      if ({got1[0], got1[1]} !== {6'h10, 6'h1F}) begin
        n_err++;
        $display("FAIL route_d1: got %h,%h want 10,1f", got1[0], got1[1]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_wrr();
    test_pause();
    test_reset_mid();
    test_routing();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
